// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in
// clk cycles, and flags a stall when rising edges stop arriving in time.
module pwm_capture #(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pwm_in,
  input  logic [COUNTER_WIDTH-1:0] timeout_cycles,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     meas_valid,
  output logic [15:0]              meas_count,
  output logic                     stalled,
  output logic                     stall_level
);

  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned SW = SYNC_STAGES;
  localparam int unsigned MW = 16;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_STALLED = 2'd3;

  logic [SW-1:0] sync_q;
  logic          s_d_q;
  logic          s_in_c;
  logic          rise_c;
  logic          timeout_en_c;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_time_q, high_time_d;
  logic          meas_valid_q, meas_valid_d;
  logic [MW-1:0] meas_count_q, meas_count_d;
  logic          stalled_q, stalled_d;
  logic          stall_level_q, stall_level_d;

  logic [CW-1:0] period_inc_c;
  logic [CW-1:0] high_inc_c;
  logic [CW-1:0] wait_inc_c;

  assign s_in_c       = sync_q[SW-1];
  assign rise_c       = s_in_c & ~s_d_q;
  assign timeout_en_c = (timeout_cycles != '0);

  // Saturating increments: long gaps pin at all-ones instead of wrapping
  assign period_inc_c = (period_cnt_q == CNT_MAX) ? CNT_MAX : period_cnt_q + CNT_ONE;
  assign high_inc_c   = (high_cnt_q   == CNT_MAX) ? CNT_MAX : high_cnt_q   + CNT_ONE;
  assign wait_inc_c   = (wait_cnt_q   == CNT_MAX) ? CNT_MAX : wait_cnt_q   + CNT_ONE;

  // Input synchronizer chain plus a one-cycle delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SW-2:0], pwm_in};
      s_d_q  <= s_in_c;
    end
  end

  // Next-state and measurement update logic
  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    period_d      = period_q;
    high_time_d   = high_time_q;
    meas_valid_d  = 1'b0;
    meas_count_d  = meas_count_q;
    stalled_d     = stalled_q;
    stall_level_d = stall_level_q;

    if (!enable) begin
      // Disabling drops any partial measurement but keeps the published results
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      wait_cnt_d   = '0;
      stalled_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          period_cnt_d = '0;
          high_cnt_d   = '0;
          wait_cnt_d   = '0;
          state_d      = ST_ARM;
        end
        ST_ARM: begin
          // First edge only establishes the phase; nothing is published
          if (rise_c) begin
            state_d      = ST_MEASURE;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            wait_cnt_d   = '0;
          end else if (timeout_en_c && (wait_cnt_q >= timeout_cycles)) begin
            state_d       = ST_STALLED;
            stalled_d     = 1'b1;
            stall_level_d = s_in_c;
          end else begin
            wait_cnt_d = wait_inc_c;
          end
        end
        ST_MEASURE: begin
          // A rise wins over a coincident timeout
          if (rise_c) begin
            period_d     = period_cnt_q;
            high_time_d  = high_cnt_q;
            meas_valid_d = 1'b1;
            meas_count_d = meas_count_q + MW'(1);
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end else if (timeout_en_c && (period_cnt_q >= timeout_cycles)) begin
            state_d       = ST_STALLED;
            stalled_d     = 1'b1;
            stall_level_d = s_in_c;
          end else begin
            period_cnt_d = period_inc_c;
            if (s_in_c) begin
              high_cnt_d = high_inc_c;
            end
          end
        end
        ST_STALLED: begin
          // Recovery edge restarts the period without publishing it
          if (rise_c) begin
            state_d      = ST_MEASURE;
            stalled_d    = 1'b0;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      period_q      <= '0;
      high_time_q   <= '0;
      meas_valid_q  <= 1'b0;
      meas_count_q  <= '0;
      stalled_q     <= 1'b0;
      stall_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      period_q      <= period_d;
      high_time_q   <= high_time_d;
      meas_valid_q  <= meas_valid_d;
      meas_count_q  <= meas_count_d;
      stalled_q     <= stalled_d;
      stall_level_q <= stall_level_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_time_q;
  assign meas_valid  = meas_valid_q;
  assign meas_count  = meas_count_q;
  assign stalled     = stalled_q;
  assign stall_level = stall_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed scenarios plus randomized PWM traffic, compared each
// cycle against a timestamp-based reference model of the capture rules.
module tb_pwm_capture;

  localparam int CW = 8;
  localparam int SS = 2;
  localparam longint MAXV = (longint'(1) << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          pwm_in;
  logic [CW-1:0] timeout_cycles;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic [15:0]   meas_count;
  logic          stalled;
  logic          stall_level;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pwm_capture #(.COUNTER_WIDTH(CW), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .pwm_in         (pwm_in),
    .timeout_cycles (timeout_cycles),
    .period         (period),
    .high_time      (high_time),
    .meas_valid     (meas_valid),
    .meas_count     (meas_count),
    .stalled        (stalled),
    .stall_level    (stall_level)
  );

  always #5 clk = ~clk;

  // Reference model: timestamps of edges rather than running counters
  typedef enum int {M_IDLE, M_ARM, M_MEAS, M_STALL} mode_t;
  mode_t         mode = M_IDLE;
  longint        n = 0;
  longint        t_ref = 0;
  longint        highs = 0;
  bit            hist [SS+1];
  logic [CW-1:0] e_period = '0;
  logic [CW-1:0] e_high = '0;
  logic          e_valid = 1'b0;
  logic [15:0]   e_count = '0;
  logic          e_stalled = 1'b0;
  logic          e_level = 1'b0;

  function automatic longint sat(input longint v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic bit timed_out(input longint elapsed);
    return (timeout_cycles != '0) && (sat(elapsed) >= longint'(timeout_cycles));
  endfunction

  task automatic model_step();
    bit s_in;
    bit rise;
    s_in = hist[SS-1];
    rise = s_in && !hist[SS];
    n = n + 1;
    e_valid = 1'b0;
    if (rst) begin
      mode = M_IDLE; e_period = '0; e_high = '0; e_count = '0;
      e_stalled = 1'b0; e_level = 1'b0; highs = 0; t_ref = 0;
    end else if (!enable) begin
      mode = M_IDLE;
      e_stalled = 1'b0;
    end else begin
      case (mode)
        M_IDLE: begin
          mode = M_ARM;
          t_ref = n + 1;
        end
        M_ARM: begin
          if (rise) begin
            mode = M_MEAS; t_ref = n; highs = 0;
          end else if (timed_out(n - t_ref)) begin
            mode = M_STALL; e_stalled = 1'b1; e_level = s_in;
          end
        end
        M_MEAS: begin
          if (rise) begin
            e_period = CW'(sat(n - t_ref));
            e_high   = CW'(sat(highs));
            e_valid  = 1'b1;
            e_count  = e_count + 16'd1;
            t_ref = n; highs = 0;
          end else if (timed_out(n - t_ref)) begin
            mode = M_STALL; e_stalled = 1'b1; e_level = s_in;
          end
        end
        default: begin
          if (rise) begin
            mode = M_MEAS; t_ref = n; highs = 0; e_stalled = 1'b0;
          end
        end
      endcase
      if (mode == M_MEAS && s_in) highs = highs + 1;
    end
    for (int i = SS; i > 0; i--) hist[i] = rst ? 1'b0 : hist[i-1];
    hist[0] = rst ? 1'b0 : pwm_in;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i <= SS; i++) hist[i] = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("period",      32'(period),      32'(e_period));
        check("high_time",   32'(high_time),   32'(e_high));
        check("meas_valid",  32'(meas_valid),  32'(e_valid));
        check("meas_count",  32'(meas_count),  32'(e_count));
        check("stalled",     32'(stalled),     32'(e_stalled));
        check("stall_level", 32'(stall_level), 32'(e_level));
      end
    end
  end

  task automatic run_pwm(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int c = 0; c < per; c++) begin
        pwm_in = (c < hi);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int kind, per, hi, lat, t_mv, t_st;
    rst = 1'b1; enable = 1'b0; pwm_in = 1'b0; timeout_cycles = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_period", 32'(period), 32'd0);
    check("rst_count",  32'(meas_count), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd0);

    // Steady 10/3 waveform with the timeout disabled
    rst = 1'b0; enable = 1'b1;
    run_pwm(10, 3, 5);
    check("w10_period", 32'(period), 32'd10);
    check("w10_high",   32'(high_time), 32'd3);
    check("w10_count",  32'(meas_count), 32'd4);
    lat = 0;
    pwm_in = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (meas_valid && lat == 0) lat = i;
      pwm_in = (i < 3);
    end
    check("latency", 32'(lat), 32'(SS + 1));
    check("w10_count2", 32'(meas_count), 32'd5);

    // 100/50 waveform then held low: stall exactly 200 cycles after last measurement
    timeout_cycles = CW'(200);
    run_pwm(100, 50, 2);
    t_mv = 0; t_st = 0;
    pwm_in = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      pwm_in = (i < 50);
      if (meas_valid) t_mv = i;
      if (stalled) begin
        t_st = i;
        break;
      end
    end
    check("stall_mv_lat", 32'(t_mv), 32'd3);
    check("stall_delay",  32'(t_st - t_mv), 32'd200);
    check("stall_level0", 32'(stall_level), 32'd0);
    check("stall_period", 32'(period), 32'd100);
    check("stall_high",   32'(high_time), 32'd50);
    check("stall_count",  32'(meas_count), 32'd8);
    run_pwm(40, 10, 3);
    check("recov_period",  32'(period), 32'd40);
    check("recov_high",    32'(high_time), 32'd10);
    check("recov_count",   32'(meas_count), 32'd10);
    check("recov_stalled", 32'(stalled), 32'd0);

    // Period longer than the counter range saturates
    timeout_cycles = '0;
    run_pwm(300, 100, 3);
    check("sat_period", 32'(period), 32'd255);
    check("sat_high",   32'(high_time), 32'd100);
    check("sat_count",  32'(meas_count), 32'd13);

    // Rise arriving exactly at the timeout count is measured
    timeout_cycles = CW'(10);
    run_pwm(10, 4, 4);
    check("edge_period",  32'(period), 32'd10);
    check("edge_high",    32'(high_time), 32'd4);
    check("edge_stalled", 32'(stalled), 32'd0);
    check("edge_count",   32'(meas_count), 32'd16);

    // Disable mid-period: outputs hold, two rises needed after re-enable
    timeout_cycles = '0;
    run_pwm(10, 4, 1);
    enable = 1'b0;
    run_pwm(10, 4, 2);
    check("dis_period", 32'(period), 32'd10);
    check("dis_high",   32'(high_time), 32'd4);
    check("dis_count",  32'(meas_count), 32'd17);
    enable = 1'b1;
    run_pwm(10, 4, 1);
    check("reen_count1", 32'(meas_count), 32'd17);
    run_pwm(10, 4, 1);
    check("reen_count2", 32'(meas_count), 32'd18);

    // Reset coincident with a measuring rise
    pwm_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstrise_valid",  32'(meas_valid), 32'd0);
    check("rstrise_period", 32'(period), 32'd0);
    check("rstrise_high",   32'(high_time), 32'd0);
    check("rstrise_count",  32'(meas_count), 32'd0);
    rst = 1'b0; pwm_in = 1'b0;

    // Randomized traffic
    for (int seg = 0; seg < 160; seg++) begin
      kind = int'($urandom_range(0, 11));
      case (kind)
        0: timeout_cycles = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom_range(1, 60));
        1: begin
          enable = 1'b0;
          repeat ($urandom_range(1, 12)) begin
            pwm_in = 1'($urandom_range(0, 1));
            @(negedge clk);
          end
          enable = 1'b1;
        end
        2: begin
          rst = 1'b1;
          repeat ($urandom_range(1, 2)) @(negedge clk);
          rst = 1'b0;
        end
        3: begin
          pwm_in = 1'($urandom_range(0, 1));
          repeat ($urandom_range(20, 120)) @(negedge clk);
        end
        4: repeat (30) begin
          pwm_in = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        default: begin
          per = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 320)) : int'($urandom_range(1, 40));
          hi  = int'($urandom_range(0, per));
          run_pwm(per, hi, int'($urandom_range(1, 4)));
        end
      endcase
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL take parameter COUNTER_WIDTH, default 32, which sets the width of every cycle counter and measurement output.
REQ-002 The block SHALL take parameter SYNC_STAGES, default 2, which sets the number of input synchronizer flops (legal range 2..4).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  measurement enable; low forces IDLE.
REQ-006 pwm_in  input  1  asynchronous PWM waveform returned from the ASIC or loopback.
REQ-007 timeout_cycles  input  COUNTER_WIDTH  stall threshold in clk cycles; 0 disables the timeout.
REQ-008 period  output  COUNTER_WIDTH  last measured period in clk cycles, rise to rise.
REQ-009 high_time  output  COUNTER_WIDTH  last measured high time in clk cycles.
REQ-010 meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-011 meas_count  output  16  number of completed measurements; wraps modulo 2^16.
REQ-012 stalled  output  1  high while in STALLED.
REQ-013 stall_level  output  1  synchronized pwm_in level captured on STALLED entry.

Function
REQ-014 pwm_in SHALL pass through a SYNC_STAGES-flop synchronizer, giving s_in; s_d SHALL be s_in delayed one cycle; rise = s_in & ~s_d.
REQ-015 FSM states SHALL be IDLE, ARM, MEASURE, STALLED.
REQ-016 IDLE: counters held at 0; when enable=1, go to ARM next cycle.
REQ-017 ARM: wait for rise; on rise, go to MEASURE with period_cnt=1 and high_cnt=1; no meas_valid.
REQ-018 MEASURE, non-rise cycle: period_cnt += 1; high_cnt += 1 when s_in=1.
REQ-019 MEASURE, rise cycle: period<=period_cnt, high_time<=high_cnt, meas_valid<=1, meas_count+=1; then period_cnt=1 and high_cnt=1.
REQ-020 Latency: a pwm_in rising edge sampled at cycle k SHALL produce rise at cycle k+SYNC_STAGES and meas_valid/outputs at cycle k+SYNC_STAGES+1.
REQ-021 period_cnt and high_cnt SHALL saturate at 2^COUNTER_WIDTH-1 and never wrap.
REQ-022 MEASURE or ARM, timeout_cycles!=0 and the stall counter reaches timeout_cycles with no rise: go to STALLED, stalled<=1, stall_level<=s_in, no meas_valid. The stall counter is period_cnt in MEASURE and a separate wait counter in ARM.
REQ-023 STALLED: period/high_time hold their last values; on rise, clear stalled and enter MEASURE with counters=1 (no meas_valid for that edge).
REQ-024 A rise in the same cycle as timeout detection SHALL take priority: normal measurement, no STALLED entry.
REQ-025 enable=0 in any state SHALL go to IDLE next cycle and clear the counters and stalled. period, high_time, meas_count and stall_level SHALL hold.
REQ-026 A constant-high or constant-low pwm_in SHALL never produce meas_valid.
REQ-027 A duty of 100% cannot be measured; a duty of 0% reaches STALLED with stall_level=0 when the timeout is enabled.

Reset
REQ-028 rst=1 SHALL clear the synchronizer, s_d, all counters, period, high_time, meas_count, meas_valid, stalled and stall_level to 0, and force IDLE.
REQ-029 rst SHALL take priority over enable and rise in the same cycle; reset mid-measurement SHALL discard the partial count.

Verification
REQ-030 enable=1, timeout_cycles=0, pwm_in period 10 / high 3, aligned to clk -> second and later meas_valid pulses show period=10, high_time=3; meas_count increments by 1 each pulse.
REQ-031 pwm_in period 100 / high 50 after a valid measurement, then held low, timeout_cycles=200 -> stalled=1 and stall_level=0 exactly 200 cycles after the last rise; the next rise clears stalled with no meas_valid; the following rise gives period equal to the new waveform.
REQ-032 COUNTER_WIDTH=8, pwm_in period 300 -> period=255 saturated, no wrap.
REQ-033 enable dropped mid-period then re-raised -> no meas_valid until the second rise after re-enable; held outputs are unchanged while disabled.
REQ-034 rst asserted during MEASURE coincident with a rise -> all outputs 0 next cycle, no meas_valid.
REQ-035 timeout_cycles=10 with pwm_in period exactly 10 -> a rise at count 10 is measured (period=10) and stalled stays 0.
